// File: rtl/result_window_accum.sv
// result_window_accum: buffers 10-bit result words in a small FIFO, sums them
// over windows of WIN samples and offers one summary per window on a
// valid/ready handshake.
// Optional feature: define RWA_MAX_TRACK_EN to build the per-window maximum
// tracker; without it out_max is tied to zero and no comparator is built.
module result_window_accum #(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned WIN        = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SUM_W      = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SUM_W-1:0]         out_sum,
    output logic [DATA_W-1:0]        out_max,
    output logic [$clog2(WIN)-1:0]   win_cnt
);

    localparam int unsigned CNT_W = $clog2(WIN);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WIN - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t              state_q;

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W:0]      count_q;
    logic [PTR_W:0]      count_d;
    logic                full_q;

    logic                push;
    logic                pop;
    logic                last_pop;
    logic [DATA_W-1:0]   pop_data;

    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_d;
    logic [CNT_W-1:0]    win_cnt_q;
    logic                out_valid_q;
    logic [SUM_W-1:0]    out_sum_q;

    // Handshake decode, pop decision and next FIFO occupancy
    always_comb begin
        push     = in_valid && !full_q && !flush;
        pop      = (state_q == ACCUM) && (count_q != '0) && !flush;
        last_pop = pop && (win_cnt_q == LAST_IDX);
        pop_data = mem_q[rd_ptr_q];
        sum_d    = sum_q + SUM_W'(pop_data);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    assign in_ready = !full_q && !flush;

    // FIFO storage write port (contents need no reset; pointers gate visibility)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointers, occupancy and registered full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
        end
    end

    // Window FSM: accumulate popped words, then hold the summary until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            sum_q       <= '0;
            win_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else if (flush) begin
            state_q     <= ACCUM;
            sum_q       <= '0;
            win_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (last_pop) begin
                        out_sum_q   <= sum_d;
                        out_valid_q <= 1'b1;
                        sum_q       <= '0;
                        win_cnt_q   <= '0;
                        state_q     <= HOLD;
                    end else if (pop) begin
                        sum_q     <= sum_d;
                        win_cnt_q <= win_cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

`ifdef RWA_MAX_TRACK_EN
    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] max_d;
    logic [DATA_W-1:0] out_max_q;

    // Running maximum including the word being popped
    always_comb begin
        max_d = (pop_data > max_q) ? pop_data : max_q;
    end

    // Maximum tracker, updated on the same pops as the running sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q     <= '0;
            out_max_q <= '0;
        end else if (flush) begin
            max_q <= '0;
        end else if (last_pop) begin
            out_max_q <= max_d;
            max_q     <= '0;
        end else if (pop) begin
            max_q <= max_d;
        end
    end

    assign out_max = out_max_q;
`else
    assign out_max = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign win_cnt   = win_cnt_q;

endmodule

// File: tb/tb_result_window_accum.sv
// Bench for result_window_accum: a queue-based window model checked every
// cycle, plus directed scenarios with hand-computed summaries.
module tb_result_window_accum;

    localparam int DATA_W = 10;
    localparam int WIN    = 4;
    localparam int DEPTH  = 4;
    localparam int SUM_W  = 12;
`ifdef RWA_MAX_TRACK_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic [DATA_W-1:0] in_data   = '0;
    logic              flush     = 1'b0;
    logic              out_ready = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [SUM_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_max;
    logic [1:0]        win_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    result_window_accum #(
        .DATA_W    (DATA_W),
        .WIN       (WIN),
        .FIFO_DEPTH(DEPTH),
        .SUM_W     (SUM_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_max  (out_max),
        .win_cnt  (win_cnt)
    );

    function automatic int mx(input int v);
        return MAX_EN ? v : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: FIFO contents and current window as queues
    int fifo_q[$];
    int win_q[$];
    bit m_valid = 1'b0;
    int m_sum   = 0;
    int m_max   = 0;

    always @(posedge clk or negedge rst_n) begin
        bit acc;
        int w;
        int s;
        int m;
        if (!rst_n) begin
            fifo_q.delete();
            win_q.delete();
            m_valid = 1'b0;
            m_sum   = 0;
            m_max   = 0;
        end else begin
            acc = in_valid && (fifo_q.size() < DEPTH) && !flush;
            if (flush) begin
                fifo_q.delete();
                win_q.delete();
                m_valid = 1'b0;
            end else begin
                if (m_valid) begin
                    if (out_ready) m_valid = 1'b0;
                end else if (fifo_q.size() > 0) begin
                    w = fifo_q.pop_front();
                    win_q.push_back(w);
                    if (win_q.size() == WIN) begin
                        s = 0;
                        m = 0;
                        foreach (win_q[i]) begin
                            s += win_q[i];
                            if (win_q[i] > m) m = win_q[i];
                        end
                        m_sum   = s;
                        m_max   = mx(m);
                        m_valid = 1'b1;
                        win_q.delete();
                    end
                end
                if (acc) fifo_q.push_back(int'(in_data));
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            chk("in_ready",  32'(in_ready),  32'((fifo_q.size() < DEPTH) && !flush));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("win_cnt",   32'(win_cnt),   32'(win_q.size()));
            chk("out_sum",   32'(out_sum),   32'(m_sum));
            chk("out_max",   32'(out_max),   32'(m_max));
        end
    end

    task automatic drive(input bit v, input int d);
        @(negedge clk);
        in_valid = v;
        in_data  = DATA_W'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0);
    endtask

    task automatic expect_summary(input string name, input int budget, input int esum, input int emax);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            #3;
            if (out_valid === 1'b1) break;
            n++;
        end
        chk({name, "_seen"}, 32'(n < budget), 32'd1);
        if (n < budget) begin
            chk({name, "_sum"}, 32'(out_sum), 32'(esum));
            chk({name, "_max"}, 32'(out_max), 32'(mx(emax)));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit resumed;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_max",   32'(out_max),   32'd0);
        chk("rst_win_cnt",   32'(win_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1,2,3,4 back-to-back: summary visible exactly one cycle, two after last accept
        out_ready = 1'b1;
        drive(1'b1, 1);
        drive(1'b1, 2);
        drive(1'b1, 3);
        drive(1'b1, 4);
        drive(1'b0, 0);
        #3;
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        #3;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_sum",   32'(out_sum),   32'd10);
        chk("t1_max",   32'(out_max),   32'(mx(4)));
        @(negedge clk);
        #3;
        chk("t1_drop",    32'(out_valid), 32'd0);
        chk("t1_win_cnt", 32'(win_cnt),   32'd0);

        // Full-scale words: no wrap in the sum
        repeat (4) drive(1'b1, 1023);
        drive(1'b0, 0);
        expect_summary("t2", 8, 4092, 1023);
        idle(2);

        // Stalled sink: summary held stable, FIFO fills, 9th word stalls
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) drive(1'b1, 11 + k);
        drive(1'b1, 19);
        #3;
        chk("t3_full_ready", 32'(in_ready),  32'd0);
        chk("t3_hold_valid", 32'(out_valid), 32'd1);
        chk("t3_hold_sum",   32'(out_sum),   32'd50);
        chk("t3_hold_max",   32'(out_max),   32'(mx(14)));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #3;
            chk("t3_stall_ready", 32'(in_ready), 32'd0);
            chk("t3_stable_sum",  32'(out_sum),  32'd50);
        end
        @(negedge clk);
        out_ready = 1'b1;
        resumed = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #3;
            if (in_ready) begin
                resumed = 1'b1;
                break;
            end
        end
        chk("t3_resume", 32'(resumed), 32'd1);
        drive(1'b0, 0);
        expect_summary("t3b", 10, 66, 18);

        // Flush during a partial window drops the concurrent push
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b1, 7);
        drive(1'b1, 8);
        drive(1'b1, 9);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = DATA_W'(100);
        flush    = 1'b1;
        #3;
        chk("t4_flush_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #3;
        chk("t4_win_cnt",   32'(win_cnt),   32'd0);
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        #3;
        chk("t4_empty", 32'(win_cnt), 32'd0);
        repeat (4) drive(1'b1, 5);
        drive(1'b0, 0);
        expect_summary("t4", 8, 20, 5);
        idle(2);

        // Asynchronous reset while holding a summary
        out_ready = 1'b0;
        repeat (4) drive(1'b1, 6);
        drive(1'b0, 0);
        expect_summary("t5", 8, 24, 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid",   32'(out_valid), 32'd0);
        chk("t5_rst_sum",     32'(out_sum),   32'd0);
        chk("t5_rst_ready",   32'(in_ready),  32'd1);
        chk("t5_rst_win_cnt", 32'(win_cnt),   32'd0);
        chk("t5_rst_max",     32'(out_max),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) drive(1'b1, 2);
        drive(1'b0, 0);
        expect_summary("t5b", 8, 8, 2);
        idle(3);

        // Sparse input: one word every third cycle
        drive(1'b1, 3);
        idle(2);
        drive(1'b1, 6);
        idle(2);
        drive(1'b1, 9);
        idle(2);
        drive(1'b1, 12);
        drive(1'b0, 0);
        #3;
        chk("t6_lat1", 32'(out_valid), 32'd0);
        @(negedge clk);
        #3;
        chk("t6_lat2_valid", 32'(out_valid), 32'd1);
        chk("t6_sum",        32'(out_sum),   32'd30);
        chk("t6_max",        32'(out_max),   32'(mx(12)));
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
